// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises and filters the raw PS/2 lines, deserialises
// 11-bit frames and folds the E0/F0 prefixes into flags on a single-cycle key strobe.
module ps2_key_rx #(
  parameter int C_filter  = 8,
  parameter int C_timeout = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_released,
  output logic       key_extended,
  output logic       err_parity,
  output logic       err_frame,
  output logic       busy
);
  localparam int WW = $clog2(C_timeout + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic          fclk_q, fclk_d, fall_q, fall_d;
  logic [7:0]    fcnt_q, fcnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          rel_q, rel_d, ext_q, ext_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [7:0]    code_q, code_d;
  logic          krel_q, krel_d, kext_q, kext_d;
  logic          valid_q, valid_d, errp_q, errp_d, errf_q, errf_d;
  logic          busy_q, busy_d;
  logic          timeout;

  // Synchronisers and the ps2clk glitch filter; the fall event is registered so
  // that it lines up with the synchronised data bit it qualifies.
  always_comb begin
    clk_s1_d  = ps2clk;
    clk_s2_d  = clk_s1_q;
    data_s1_d = ps2data;
    data_s2_d = data_s1_q;
    fclk_d    = fclk_q;
    fcnt_d    = '0;
    fall_d    = 1'b0;
    if (clk_s2_q != fclk_q) begin
      if (fcnt_q == 8'(C_filter - 1)) begin
        fclk_d = ~fclk_q;
        fall_d = fclk_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  // Frame FSM; a watchdog expiry takes priority over a coincident fall event.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    rel_d    = rel_q;
    ext_d    = ext_q;
    code_d   = code_q;
    krel_d   = krel_q;
    kext_d   = kext_q;
    valid_d  = 1'b0;
    errp_d   = 1'b0;
    errf_d   = 1'b0;
    wdog_d   = (state_q == S_IDLE || fall_q) ? '0 : wdog_q + WW'(1);
    timeout  = (state_q != S_IDLE) && (wdog_q == WW'(C_timeout));
    if (timeout) begin
      state_d = S_IDLE;
      errf_d  = 1'b1;
      rel_d   = 1'b0;
      ext_d   = 1'b0;
      wdog_d  = '0;
    end else if (fall_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (!data_s2_q) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
        S_DATA: begin
          shreg_d  = {data_s2_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = data_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!data_s2_q || !(^{shreg_q, par_q})) begin
            errf_d = !data_s2_q;
            errp_d = data_s2_q;
            rel_d  = 1'b0;
            ext_d  = 1'b0;
          end else if (shreg_q == 8'hF0) begin
            rel_d = 1'b1;
          end else if (shreg_q == 8'hE0) begin
            ext_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            code_d  = shreg_q;
            krel_d  = rel_q;
            kext_d  = ext_q;
            rel_d   = 1'b0;
            ext_d   = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
      fclk_q    <= 1'b1;
      fcnt_q    <= '0;
      fall_q    <= 1'b0;
      state_q   <= S_IDLE;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      rel_q     <= 1'b0;
      ext_q     <= 1'b0;
      wdog_q    <= '0;
      code_q    <= '0;
      krel_q    <= 1'b0;
      kext_q    <= 1'b0;
      valid_q   <= 1'b0;
      errp_q    <= 1'b0;
      errf_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      clk_s1_q  <= clk_s1_d;
      clk_s2_q  <= clk_s2_d;
      data_s1_q <= data_s1_d;
      data_s2_q <= data_s2_d;
      fclk_q    <= fclk_d;
      fcnt_q    <= fcnt_d;
      fall_q    <= fall_d;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      rel_q     <= rel_d;
      ext_q     <= ext_d;
      wdog_q    <= wdog_d;
      code_q    <= code_d;
      krel_q    <= krel_d;
      kext_q    <= kext_d;
      valid_q   <= valid_d;
      errp_q    <= errp_d;
      errf_q    <= errf_d;
      busy_q    <= busy_d;
    end
  end

  assign key_code     = code_q;
  assign key_valid    = valid_q;
  assign key_released = krel_q;
  assign key_extended = kext_q;
  assign err_parity   = errp_q;
  assign err_frame    = errf_q;
  assign busy         = busy_q;
endmodule
